// File: rtl/issue_scoreboard_pkg.sv
// -----------------------------------------------------------------------------
// issue_scoreboard_pkg
// Shared constants for the ID-stage dual-issue hazard scoreboard:
//   ARF_SEL            architectural register index width (32 registers)
//   NUM_REGS           number of architectural registers
//   LAT_W              latency-class width
//   LAT_EX1..LAT_EX4   latency-class encodings (stage where result is final)
//   MAX_LAT            largest legal latency class
//   R0_IDX             index of the hardwired-zero register
//   sat_lat()          clamps an out-of-range latency class to MAX_LAT
// -----------------------------------------------------------------------------
package issue_scoreboard_pkg;

  localparam int ARF_SEL  = 5;
  localparam int NUM_REGS = 1 << ARF_SEL;
  localparam int LAT_W    = 2;

  localparam logic [LAT_W-1:0] LAT_EX1 = 2'd0;
  localparam logic [LAT_W-1:0] LAT_EX2 = 2'd1;
  localparam logic [LAT_W-1:0] LAT_EX3 = 2'd2;
  localparam logic [LAT_W-1:0] LAT_EX4 = 2'd3;
  localparam logic [LAT_W-1:0] MAX_LAT = LAT_EX4;

  localparam logic [ARF_SEL-1:0] R0_IDX = 5'd0;

  function automatic logic [LAT_W-1:0] sat_lat(input logic [LAT_W-1:0] lat);
    if (lat > MAX_LAT) begin
      return MAX_LAT;
    end else begin
      return lat;
    end
  endfunction

endpackage

// File: rtl/issue_scoreboard_src_ready.sv
// -----------------------------------------------------------------------------
// sb_src_ready
// Decides whether one source operand can be read at issue time.
// A source is ready when it is not used, names r0, or its register has no
// outstanding latency left in the pending vector.
// Ports:
//   i_raddr  source register index
//   i_use    source read enable
//   i_pend   per-register remaining-latency counters (entry 0 unused)
//   o_ready  source is available from the RF or the bypass network
// -----------------------------------------------------------------------------
module sb_src_ready
  import issue_scoreboard_pkg::*;
#(
  parameter int SRC_SEL = issue_scoreboard_pkg::ARF_SEL,
  parameter int SRC_LAT = issue_scoreboard_pkg::LAT_W
) (
  input  logic [SRC_SEL-1:0]                   i_raddr,
  input  logic                                 i_use,
  input  logic [(1<<SRC_SEL)-1:0][SRC_LAT-1:0] i_pend,
  output logic                                 o_ready
);

  // r0 and unused sources never wait; otherwise wait for the counter to drain
  always_comb begin
    o_ready = 1'b1;
    if (i_use && (i_raddr != SRC_SEL'(R0_IDX))) begin
      o_ready = (i_pend[i_raddr] == {SRC_LAT{1'b0}});
    end else begin
      o_ready = 1'b1;
    end
  end

endmodule

// File: rtl/issue_scoreboard.sv
// -----------------------------------------------------------------------------
// issue_scoreboard
// In-order dual-issue hazard scoreboard for the ID stage. Each architectural
// register r1..r31 carries a down-counter of cycles left until its in-flight
// producer's result is final on the EX1-WB bypass network. The pair is
// stalled or split so every issued source is in the RF or forwardable.
//
// Optional feature macro: SB_STALL_CNT_EN adds o_stall_cnt, a saturating
// count of stall cycles plus split cycles (cleared only by reset).
//
// Ports:
//   i_clk, i_rst_n               clock, async active-low reset
//   i_flush                      kill all in-flight writers, block issue
//   i_i1_* / i_i2_*              slot valid, sources, destination, latency
//   o_i1_issue, o_i2_issue       slot leaves ID this cycle (combinational)
//   o_stall_id                   slot 1 valid but not issuing
//   o_stall_cnt                  stall counter (SB_STALL_CNT_EN only)
// -----------------------------------------------------------------------------
module issue_scoreboard #(
  parameter int ARF_SEL = issue_scoreboard_pkg::ARF_SEL,
  parameter int LAT_W   = issue_scoreboard_pkg::LAT_W,
  parameter int MAX_LAT = 3
`ifdef SB_STALL_CNT_EN
  ,
  parameter int CNT_W   = 32
`endif
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_flush,
  input  logic               i_i1_vld,
  input  logic               i_i1_rs1_use,
  input  logic [ARF_SEL-1:0] i_i1_rs1_raddr,
  input  logic               i_i1_rs2_use,
  input  logic [ARF_SEL-1:0] i_i1_rs2_raddr,
  input  logic               i_i1_rd_we,
  input  logic [ARF_SEL-1:0] i_i1_rd_waddr,
  input  logic [LAT_W-1:0]   i_i1_lat,
  input  logic               i_i2_vld,
  input  logic               i_i2_rs1_use,
  input  logic [ARF_SEL-1:0] i_i2_rs1_raddr,
  input  logic               i_i2_rs2_use,
  input  logic [ARF_SEL-1:0] i_i2_rs2_raddr,
  input  logic               i_i2_rd_we,
  input  logic [ARF_SEL-1:0] i_i2_rd_waddr,
  input  logic [LAT_W-1:0]   i_i2_lat,
  output logic               o_i1_issue,
  output logic               o_i2_issue,
  output logic               o_stall_id
`ifdef SB_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0]   o_stall_cnt
`endif
);

  import issue_scoreboard_pkg::*;

  localparam int                 NREG   = 1 << ARF_SEL;
  localparam logic [ARF_SEL-1:0] RZERO  = ARF_SEL'(R0_IDX);
  localparam logic [LAT_W-1:0]   LAT_MX = LAT_W'(MAX_LAT);

  function automatic logic [LAT_W-1:0] clamp_lat(input logic [LAT_W-1:0] lat);
    if (lat > LAT_MX) begin
      return LAT_MX;
    end else begin
      return lat;
    end
  endfunction

  logic [NREG-1:0][LAT_W-1:0] pend_q;
  logic [NREG-1:0][LAT_W-1:0] pend_d;

  logic i1_rs1_rdy_s, i1_rs2_rdy_s, i2_rs1_rdy_s, i2_rs2_rdy_s;
  logic raw_s;
  logic i1_issue_s, i2_issue_s, stall_s, split_s;
  logic i1_load_s, i2_load_s;

  sb_src_ready #(.SRC_SEL(ARF_SEL), .SRC_LAT(LAT_W)) u_i1_rs1 (
    .i_raddr(i_i1_rs1_raddr), .i_use(i_i1_rs1_use), .i_pend(pend_q), .o_ready(i1_rs1_rdy_s)
  );
  sb_src_ready #(.SRC_SEL(ARF_SEL), .SRC_LAT(LAT_W)) u_i1_rs2 (
    .i_raddr(i_i1_rs2_raddr), .i_use(i_i1_rs2_use), .i_pend(pend_q), .o_ready(i1_rs2_rdy_s)
  );
  sb_src_ready #(.SRC_SEL(ARF_SEL), .SRC_LAT(LAT_W)) u_i2_rs1 (
    .i_raddr(i_i2_rs1_raddr), .i_use(i_i2_rs1_use), .i_pend(pend_q), .o_ready(i2_rs1_rdy_s)
  );
  sb_src_ready #(.SRC_SEL(ARF_SEL), .SRC_LAT(LAT_W)) u_i2_rs2 (
    .i_raddr(i_i2_rs2_raddr), .i_use(i_i2_rs2_use), .i_pend(pend_q), .o_ready(i2_rs2_rdy_s)
  );

  // Issue decision: i2 can never overtake i1, and cannot consume i1's result
  // in the same cycle because i1's value is not on the bypass yet.
  always_comb begin
    raw_s = 1'b0;
    if (i_i1_rd_we && (i_i1_rd_waddr != RZERO)) begin
      raw_s = (i_i2_rs1_use && (i_i2_rs1_raddr == i_i1_rd_waddr)) ||
              (i_i2_rs2_use && (i_i2_rs2_raddr == i_i1_rd_waddr));
    end else begin
      raw_s = 1'b0;
    end
    i1_issue_s = i_i1_vld && i1_rs1_rdy_s && i1_rs2_rdy_s && !i_flush;
    i2_issue_s = i1_issue_s && i_i2_vld && i2_rs1_rdy_s && i2_rs2_rdy_s && !raw_s;
    stall_s    = i_i1_vld && !i1_issue_s;
    split_s    = i1_issue_s && i_i2_vld && !i2_issue_s;
    i1_load_s  = i1_issue_s && i_i1_rd_we && (i_i1_rd_waddr != RZERO);
    i2_load_s  = i2_issue_s && i_i2_rd_we && (i_i2_rd_waddr != RZERO);
  end

  // Drive the issue/stall ports straight from the decision logic
  always_comb begin
    o_i1_issue = i1_issue_s;
    o_i2_issue = i2_issue_s;
    o_stall_id = stall_s;
  end

  // Next pending state: flush > new load (i2 beats i1 on WAW) > decrement.
  // Decrement ignores the ID stall because EX keeps draining.
  always_comb begin
    pend_d    = pend_q;
    pend_d[0] = {LAT_W{1'b0}};
    for (int r = 1; r < NREG; r++) begin
      if (i_flush) begin
        pend_d[r] = {LAT_W{1'b0}};
      end else if (i2_load_s && (i_i2_rd_waddr == ARF_SEL'(r))) begin
        pend_d[r] = clamp_lat(i_i2_lat);
      end else if (i1_load_s && (i_i1_rd_waddr == ARF_SEL'(r))) begin
        pend_d[r] = clamp_lat(i_i1_lat);
      end else if (pend_q[r] != {LAT_W{1'b0}}) begin
        pend_d[r] = pend_q[r] - LAT_W'(1);
      end else begin
        pend_d[r] = pend_q[r];
      end
    end
  end

  // Pending-latency counters
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pend_q <= {(NREG*LAT_W){1'b0}};
    end else begin
      pend_q <= pend_d;
    end
  end

`ifdef SB_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] stall_cnt_d;

  // Count stall and split cycles, holding at all-ones; flush does not clear it
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((stall_s || split_s) && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Stall counter register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stall_cnt_q <= {CNT_W{1'b0}};
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign o_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_issue_scoreboard.sv
module tb_issue_scoreboard;

  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic       i_flush;
  logic       i_i1_vld, i_i1_rs1_use, i_i1_rs2_use, i_i1_rd_we;
  logic [4:0] i_i1_rs1_raddr, i_i1_rs2_raddr, i_i1_rd_waddr;
  logic [1:0] i_i1_lat;
  logic       i_i2_vld, i_i2_rs1_use, i_i2_rs2_use, i_i2_rd_we;
  logic [4:0] i_i2_rs1_raddr, i_i2_rs2_raddr, i_i2_rd_waddr;
  logic [1:0] i_i2_lat;
  logic       o_i1_issue, o_i2_issue, o_stall_id;
`ifdef SB_STALL_CNT_EN
  logic [31:0] o_stall_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 i_clk = ~i_clk;

  issue_scoreboard dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_flush(i_flush),
    .i_i1_vld(i_i1_vld), .i_i1_rs1_use(i_i1_rs1_use), .i_i1_rs1_raddr(i_i1_rs1_raddr),
    .i_i1_rs2_use(i_i1_rs2_use), .i_i1_rs2_raddr(i_i1_rs2_raddr),
    .i_i1_rd_we(i_i1_rd_we), .i_i1_rd_waddr(i_i1_rd_waddr), .i_i1_lat(i_i1_lat),
    .i_i2_vld(i_i2_vld), .i_i2_rs1_use(i_i2_rs1_use), .i_i2_rs1_raddr(i_i2_rs1_raddr),
    .i_i2_rs2_use(i_i2_rs2_use), .i_i2_rs2_raddr(i_i2_rs2_raddr),
    .i_i2_rd_we(i_i2_rd_we), .i_i2_rd_waddr(i_i2_rd_waddr), .i_i2_lat(i_i2_lat),
    .o_i1_issue(o_i1_issue), .o_i2_issue(o_i2_issue), .o_stall_id(o_stall_id)
`ifdef SB_STALL_CNT_EN
    , .o_stall_cnt(o_stall_cnt)
`endif
  );

  task automatic drive_i1(input logic vld, input logic u1, input logic [4:0] s1,
                          input logic u2, input logic [4:0] s2,
                          input logic we, input logic [4:0] rd, input logic [1:0] lat);
    i_i1_vld = vld; i_i1_rs1_use = u1; i_i1_rs1_raddr = s1;
    i_i1_rs2_use = u2; i_i1_rs2_raddr = s2;
    i_i1_rd_we = we; i_i1_rd_waddr = rd; i_i1_lat = lat;
  endtask

  task automatic drive_i2(input logic vld, input logic u1, input logic [4:0] s1,
                          input logic u2, input logic [4:0] s2,
                          input logic we, input logic [4:0] rd, input logic [1:0] lat);
    i_i2_vld = vld; i_i2_rs1_use = u1; i_i2_rs1_raddr = s1;
    i_i2_rs2_use = u2; i_i2_rs2_raddr = s2;
    i_i2_rd_we = we; i_i2_rd_waddr = rd; i_i2_lat = lat;
  endtask

  task automatic drive_idle;
    i_flush = 1'b0;
    drive_i1(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 2'd0);
    drive_i2(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 2'd0);
  endtask

  task automatic next_cycle;
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset;
    i_rst_n = 1'b0;
    drive_idle();
    repeat (2) @(posedge i_clk);
    #1;
    drive_i1(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 2'd0);
    drive_i2(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 2'd0);
    @(negedge i_clk);
    n_cmp++; if (o_i1_issue !== 1'b1) begin n_bad++; $display("FAIL reset_i1_issue: got %b expected 1", o_i1_issue); end
    n_cmp++; if (o_i2_issue !== 1'b1) begin n_bad++; $display("FAIL reset_i2_issue: got %b expected 1", o_i2_issue); end
    n_cmp++; if (o_stall_id !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b expected 0", o_stall_id); end
`ifdef SB_STALL_CNT_EN
    n_cmp++; if (o_stall_cnt !== 32'd0) begin n_bad++; $display("FAIL reset_cnt: got %0d expected 0", o_stall_cnt); end
`endif
    drive_idle();
    @(negedge i_clk);
    i_rst_n = 1'b1;
    next_cycle();
  endtask

  task automatic test_lat0_pair;
    // add r4 / sub r5, both latency 0
    drive_i1(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd4, 2'd0);
    drive_i2(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd5, 2'd0);
    @(negedge i_clk);
    n_cmp++; if (o_i1_issue !== 1'b1 || o_i2_issue !== 1'b1 || o_stall_id !== 1'b0) begin
      n_bad++; $display("FAIL lat0_producers: got i1=%b i2=%b stall=%b expected 1 1 0", o_i1_issue, o_i2_issue, o_stall_id);
    end
    next_cycle();
    drive_i1(1'b1, 1'b1, 5'd4, 1'b1, 5'd5, 1'b0, 5'd0, 2'd0);
    drive_i2(1'b1, 1'b1, 5'd5, 1'b1, 5'd4, 1'b0, 5'd0, 2'd0);
    @(negedge i_clk);
    n_cmp++; if (o_i1_issue !== 1'b1 || o_i2_issue !== 1'b1 || o_stall_id !== 1'b0) begin
      n_bad++; $display("FAIL lat0_readers: got i1=%b i2=%b stall=%b expected 1 1 0", o_i1_issue, o_i2_issue, o_stall_id);
    end
    next_cycle();
    drive_idle();
  endtask

  task automatic test_load_use;
    // ld r6, latency 3
    drive_i1(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd6, 2'd3);
    @(negedge i_clk);
    n_cmp++; if (o_i1_issue !== 1'b1) begin n_bad++; $display("FAIL load_issue: got %b expected 1", o_i1_issue); end
    next_cycle();
    drive_i1(1'b1, 1'b1, 5'd6, 1'b0, 5'd0, 1'b1, 5'd11, 2'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge i_clk);
      n_cmp++; if (o_stall_id !== 1'b1 || o_i1_issue !== 1'b0) begin
        n_bad++; $display("FAIL load_use_stall%0d: got stall=%b issue=%b expected 1 0", c, o_stall_id, o_i1_issue);
      end
      next_cycle();
    end
    @(negedge i_clk);
    n_cmp++; if (o_stall_id !== 1'b0 || o_i1_issue !== 1'b1) begin
      n_bad++; $display("FAIL load_use_release: got stall=%b issue=%b expected 0 1", o_stall_id, o_i1_issue);
    end
`ifdef SB_STALL_CNT_EN
    n_cmp++; if (o_stall_cnt !== 32'd3) begin n_bad++; $display("FAIL load_use_cnt: got %0d expected 3", o_stall_cnt); end
`endif
    next_cycle();
    drive_idle();
  endtask

  task automatic test_split;
    // i1 writes r7, i2 reads r7 in the same pair
    drive_i1(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd7, 2'd0);
    drive_i2(1'b1, 1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 5'd0, 2'd0);
    @(negedge i_clk);
    n_cmp++; if (o_i1_issue !== 1'b1 || o_i2_issue !== 1'b0 || o_stall_id !== 1'b0) begin
      n_bad++; $display("FAIL split_pair: got i1=%b i2=%b stall=%b expected 1 0 0", o_i1_issue, o_i2_issue, o_stall_id);
    end
    next_cycle();
    drive_i1(1'b1, 1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 5'd0, 2'd0);
    drive_i2(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 2'd0);
    @(negedge i_clk);
    n_cmp++; if (o_i1_issue !== 1'b1 || o_stall_id !== 1'b0) begin
      n_bad++; $display("FAIL split_shifted: got i1=%b stall=%b expected 1 0", o_i1_issue, o_stall_id);
    end
`ifdef SB_STALL_CNT_EN
    n_cmp++; if (o_stall_cnt !== 32'd4) begin n_bad++; $display("FAIL split_cnt: got %0d expected 4", o_stall_cnt); end
`endif
    next_cycle();
    drive_idle();
  endtask

  task automatic test_waw;
    // both slots write r8: i1 lat 3, i2 lat 0 -> i2 governs
    drive_i1(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd8, 2'd3);
    drive_i2(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd8, 2'd0);
    @(negedge i_clk);
    n_cmp++; if (o_i1_issue !== 1'b1 || o_i2_issue !== 1'b1) begin
      n_bad++; $display("FAIL waw_pair: got i1=%b i2=%b expected 1 1", o_i1_issue, o_i2_issue);
    end
    next_cycle();
    drive_i1(1'b1, 1'b0, 5'd0, 1'b1, 5'd8, 1'b0, 5'd0, 2'd0);
    drive_i2(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 2'd0);
    @(negedge i_clk);
    n_cmp++; if (o_i1_issue !== 1'b1 || o_stall_id !== 1'b0) begin
      n_bad++; $display("FAIL waw_reader: got i1=%b stall=%b expected 1 0", o_i1_issue, o_stall_id);
    end
    next_cycle();
    drive_idle();
  endtask

  task automatic test_flush;
    // r9 latency 2, then flush
    drive_i1(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd9, 2'd2);
    next_cycle();
    i_flush = 1'b1;
    drive_i1(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 2'd0);
    @(negedge i_clk);
    n_cmp++; if (o_i1_issue !== 1'b0 || o_i2_issue !== 1'b0 || o_stall_id !== 1'b1) begin
      n_bad++; $display("FAIL flush_cycle: got i1=%b i2=%b stall=%b expected 0 0 1", o_i1_issue, o_i2_issue, o_stall_id);
    end
    next_cycle();
    i_flush = 1'b0;
    drive_i1(1'b1, 1'b1, 5'd9, 1'b0, 5'd0, 1'b0, 5'd0, 2'd0);
    @(negedge i_clk);
    n_cmp++; if (o_i1_issue !== 1'b1 || o_stall_id !== 1'b0) begin
      n_bad++; $display("FAIL flush_reader: got i1=%b stall=%b expected 1 0", o_i1_issue, o_stall_id);
    end
    next_cycle();
    drive_idle();
  endtask

  task automatic test_r0;
    // write r0 lat 3; i2 reading r0 in the same pair is not a RAW
    drive_i1(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd0, 2'd3);
    drive_i2(1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 2'd0);
    @(negedge i_clk);
    n_cmp++; if (o_i1_issue !== 1'b1 || o_i2_issue !== 1'b1) begin
      n_bad++; $display("FAIL r0_pair: got i1=%b i2=%b expected 1 1", o_i1_issue, o_i2_issue);
    end
    next_cycle();
    drive_i1(1'b1, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 2'd0);
    drive_i2(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 2'd0);
    @(negedge i_clk);
    n_cmp++; if (o_i1_issue !== 1'b1 || o_stall_id !== 1'b0) begin
      n_bad++; $display("FAIL r0_reader: got i1=%b stall=%b expected 1 0", o_i1_issue, o_stall_id);
    end
    next_cycle();
    drive_idle();
  endtask

  task automatic test_mid_reset;
    // r10 latency 3, then async reset while pending
    drive_i1(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd10, 2'd3);
    next_cycle();
    drive_idle();
    #2;
    i_rst_n = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    next_cycle();
    drive_i1(1'b1, 1'b1, 5'd10, 1'b0, 5'd0, 1'b0, 5'd0, 2'd0);
    @(negedge i_clk);
    n_cmp++; if (o_i1_issue !== 1'b1 || o_stall_id !== 1'b0) begin
      n_bad++; $display("FAIL mid_reset_reader: got i1=%b stall=%b expected 1 0", o_i1_issue, o_stall_id);
    end
`ifdef SB_STALL_CNT_EN
    n_cmp++; if (o_stall_cnt !== 32'd0) begin n_bad++; $display("FAIL mid_reset_cnt: got %0d expected 0", o_stall_cnt); end
`endif
    next_cycle();
    drive_idle();
  endtask

  initial begin
    test_reset();
    test_lat0_pair();
    test_load_use();
    test_split();
    test_waw();
    test_flush();
    test_r0();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
